sprite_mover: RTL and testbench

- Parametrised movable rectangular sprite for the 800x480 RGB565 LCD pipeline. Sits between the LCD timing generator, which supplies the pixel coordinates and the frame tick, and the colour mux.
- Manual mode: debounced buttons with hold-to-repeat.
- Bounce mode: autonomous diagonal motion that reflects off the screen edges.
- Position changes are applied only on the frame tick, so the sprite never tears mid-frame.

---
 rtl/lcd_pkg.sv | 36 +++
 rtl/btn_repeat.sv | 92 +++++++++
 rtl/sprite_mover.sv | 177 +++++++++++++++++
 tb/tb_sprite_mover.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD pipeline constants, mode encoding and RGB565 helper
// Purpose: default panel geometry, display mode encoding, button bit indices
//          and an RGB565 field splitter shared by the LCD pipeline blocks.
// Ports:   none (package).
package lcd_pkg;

  localparam int DEF_COORD_W  = 10;
  localparam int DEF_SCREEN_W = 800;
  localparam int DEF_SCREEN_H = 480;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_BOUNCE = 1'b1
  } mode_e;

  // Bit positions of the direction buttons inside the request/pending vectors.
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_U = 2;
  localparam int BTN_D = 3;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic rgb565_t rgb565_split(input logic [15:0] c);
    rgb565_t f;
    f.r = c[15:11];
    f.g = c[10:5];
    f.b = c[4:0];
    return f;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// rtl/btn_repeat.sv - button synchroniser, debouncer, edge detect and frame-based auto-repeat
// Purpose: turns one raw asynchronous button into one-cycle move requests:
//          one on the debounced press, then repeats while held (counted in frames).
// Ports:   i_clk, i_rst  - clock, synchronous active-high reset
//          i_btn         - raw asynchronous button level
//          i_frame       - frame tick, drives the hold/repeat counters
//          i_clear       - holds the repeat counters cleared and masks requests
//          o_req         - one-cycle move request
module btn_repeat #(
  parameter int SYNC_LEN   = 3,
  parameter int RPT_DELAY  = 20,
  parameter int RPT_PERIOD = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  input  logic i_frame,
  input  logic i_clear,
  output logic o_req
);

  localparam int DB_W   = $clog2(SYNC_LEN) + 1;
  localparam int HOLD_W = $clog2(RPT_DELAY + 1);
  localparam int PER_W  = $clog2(RPT_PERIOD) + 1;

  logic [1:0]        r_sync;
  logic              r_deb;
  logic              r_deb_q;
  logic [DB_W-1:0]   r_db_cnt;
  logic [HOLD_W-1:0] r_hold;
  logic [PER_W-1:0]  r_per;
  logic              w_sync;
  logic              w_rise;
  logic              w_rpt;

  assign w_sync = r_sync[1];
  assign w_rise = r_deb & ~r_deb_q;

  // Repeat fires on the frame where the hold count reaches RPT_DELAY, then
  // every RPT_PERIOD frames; r_hold saturates and r_per takes over.
  always_comb begin
    w_rpt = 1'b0;
    if (i_frame && r_deb) begin
      if (r_hold < HOLD_W'(RPT_DELAY))
        w_rpt = (r_hold == HOLD_W'(RPT_DELAY - 1));
      else
        w_rpt = (r_per == PER_W'(RPT_PERIOD - 1));
    end
  end

  assign o_req = (w_rise | w_rpt) & ~i_clear;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync   <= '0;
      r_deb    <= 1'b0;
      r_deb_q  <= 1'b0;
      r_db_cnt <= '0;
      r_hold   <= '0;
      r_per    <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_deb_q <= r_deb;

      // Samples differing from the debounced level are counted; any sample
      // agreeing with it restarts the run, so only SYNC_LEN in a row flip it.
      if (w_sync == r_deb) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(SYNC_LEN - 1)) begin
        r_deb    <= w_sync;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end

      if (!r_deb || i_clear) begin
        r_hold <= '0;
        r_per  <= '0;
      end else if (i_frame) begin
        if (r_hold < HOLD_W'(RPT_DELAY)) begin
          r_hold <= r_hold + 1'b1;
          r_per  <= '0;
        end else if (r_per == PER_W'(RPT_PERIOD - 1)) begin
          r_per <= '0;
        end else begin
          r_per <= r_per + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sprite_mover.sv
// rtl/sprite_mover.sv - movable rectangular sprite with manual and bounce modes
// Purpose: keeps the sprite position (button driven or bouncing), updates it
//          only on the frame tick, and flags/colours pixels inside the sprite.
// Ports:   i_clk, i_rst          - pixel clock, synchronous active-high reset
//          i_x, i_y              - current pixel coordinates
//          i_frame               - one-cycle tick at start of vertical blanking
//          i_mode                - 0 manual, 1 bounce (sampled on i_frame)
//          left/right/up/down    - raw asynchronous buttons
//          o_R, o_G, o_B, o_on   - registered pixel colour and inside flag
//          o_xpos, o_ypos        - sprite top-left position
module sprite_mover
  import lcd_pkg::*;
#(
  parameter int          COORD_W    = DEF_COORD_W,
  parameter int          SCREEN_W   = DEF_SCREEN_W,
  parameter int          SCREEN_H   = DEF_SCREEN_H,
  parameter int          SPR_W      = 50,
  parameter int          SPR_H      = 50,
  parameter int          STEP       = 1,
  parameter int          SYNC_LEN   = 3,
  parameter int          RPT_DELAY  = 20,
  parameter int          RPT_PERIOD = 4,
  parameter logic [15:0] COLOR      = 16'h07FF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_frame,
  input  logic               i_mode,
  input  logic               left,
  input  logic               right,
  input  logic               up,
  input  logic               down,
  output logic [4:0]         o_R,
  output logic [5:0]         o_G,
  output logic [4:0]         o_B,
  output logic               o_on,
  output logic [COORD_W-1:0] o_xpos,
  output logic [COORD_W-1:0] o_ypos
);

  localparam logic signed [COORD_W:0] X_MAX_S = (COORD_W+1)'(SCREEN_W - SPR_W);
  localparam logic signed [COORD_W:0] Y_MAX_S = (COORD_W+1)'(SCREEN_H - SPR_H);
  localparam logic signed [COORD_W:0] STEP_S  = (COORD_W+1)'(STEP);
  localparam logic signed [COORD_W:0] ZERO_S  = '0;
  localparam logic [COORD_W-1:0]      X_INIT  = COORD_W'((SCREEN_W - SPR_W) / 2);
  localparam logic [COORD_W-1:0]      Y_INIT  = COORD_W'((SCREEN_H - SPR_H) / 2);
  localparam logic [COORD_W:0]        SPR_W_U = (COORD_W+1)'(SPR_W);
  localparam logic [COORD_W:0]        SPR_H_U = (COORD_W+1)'(SPR_H);
  localparam rgb565_t                 C_FLD   = rgb565_split(COLOR);

  logic [3:0]                r_pend;
  logic [COORD_W-1:0]        r_xpos;
  logic [COORD_W-1:0]        r_ypos;
  logic                      r_dx_neg;
  logic                      r_dy_neg;
  mode_e                     r_mode;
  logic                      r_on;

  logic [3:0]                w_btn;
  logic [3:0]                w_req;
  logic                      w_bounce_now;
  logic signed [COORD_W:0]   w_xs, w_ys;
  logic signed [COORD_W:0]   w_x_dec, w_x_inc, w_y_dec, w_y_inc;
  logic signed [COORD_W:0]   w_bx, w_by;
  logic [COORD_W-1:0]        w_x_nxt, w_y_nxt;
  logic                      w_dx_neg_nxt, w_dy_neg_nxt;
  logic                      w_in_x, w_in_y;

  // Underflow shows up as a set sign bit in the widened value; clamp it to 0.
  function automatic logic [COORD_W-1:0] clamp_pos(input logic signed [COORD_W:0] v,
                                                   input logic signed [COORD_W:0] hi);
    if (v[COORD_W])
      return '0;
    else if (v > hi)
      return hi[COORD_W-1:0];
    else
      return v[COORD_W-1:0];
  endfunction

  // The mode seen on a frame tick applies from that tick; between ticks the
  // previously latched mode governs whether buttons are ignored.
  assign w_bounce_now = i_frame ? (i_mode == MODE_BOUNCE) : (r_mode == MODE_BOUNCE);

  assign w_btn = {down, up, right, left};

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    btn_repeat #(
      .SYNC_LEN  (SYNC_LEN),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
    ) u_btn (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_btn  (w_btn[gi]),
      .i_frame(i_frame),
      .i_clear(w_bounce_now),
      .o_req  (w_req[gi])
    );
  end

  assign w_xs    = signed'({1'b0, r_xpos});
  assign w_ys    = signed'({1'b0, r_ypos});
  assign w_x_dec = w_xs - STEP_S;
  assign w_x_inc = w_xs + STEP_S;
  assign w_y_dec = w_ys - STEP_S;
  assign w_y_inc = w_ys + STEP_S;
  assign w_bx    = r_dx_neg ? w_x_dec : w_x_inc;
  assign w_by    = r_dy_neg ? w_y_dec : w_y_inc;

  always_comb begin
    w_x_nxt      = r_xpos;
    w_y_nxt      = r_ypos;
    w_dx_neg_nxt = r_dx_neg;
    w_dy_neg_nxt = r_dy_neg;
    if (w_bounce_now) begin
      w_x_nxt = clamp_pos(w_bx, X_MAX_S);
      w_y_nxt = clamp_pos(w_by, Y_MAX_S);
      // Landing on an edge reverses at once, so an exact corner flips both.
      if (w_bx[COORD_W] || w_bx == ZERO_S) w_dx_neg_nxt = 1'b0;
      else if (w_bx >= X_MAX_S)            w_dx_neg_nxt = 1'b1;
      if (w_by[COORD_W] || w_by == ZERO_S) w_dy_neg_nxt = 1'b0;
      else if (w_by >= Y_MAX_S)            w_dy_neg_nxt = 1'b1;
    end else begin
      case ({r_pend[BTN_L], r_pend[BTN_R]})
        2'b10:   w_x_nxt = clamp_pos(w_x_dec, X_MAX_S);
        2'b01:   w_x_nxt = clamp_pos(w_x_inc, X_MAX_S);
        default: w_x_nxt = r_xpos;
      endcase
      case ({r_pend[BTN_U], r_pend[BTN_D]})
        2'b10:   w_y_nxt = clamp_pos(w_y_dec, Y_MAX_S);
        2'b01:   w_y_nxt = clamp_pos(w_y_inc, Y_MAX_S);
        default: w_y_nxt = r_ypos;
      endcase
    end
  end

  assign w_in_x = ({1'b0, i_x} >= {1'b0, r_xpos}) && ({1'b0, i_x} < ({1'b0, r_xpos} + SPR_W_U));
  assign w_in_y = ({1'b0, i_y} >= {1'b0, r_ypos}) && ({1'b0, i_y} < ({1'b0, r_ypos} + SPR_H_U));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_xpos   <= X_INIT;
      r_ypos   <= Y_INIT;
      r_dx_neg <= 1'b0;
      r_dy_neg <= 1'b0;
      r_mode   <= MODE_MANUAL;
      r_pend   <= '0;
      r_on     <= 1'b0;
    end else begin
      if (i_frame) begin
        r_mode   <= mode_e'(i_mode);
        r_xpos   <= w_x_nxt;
        r_ypos   <= w_y_nxt;
        r_dx_neg <= w_dx_neg_nxt;
        r_dy_neg <= w_dy_neg_nxt;
      end
      // Requests arriving on the tick itself become pending for the next tick.
      if (w_bounce_now)
        r_pend <= '0;
      else if (i_frame)
        r_pend <= w_req;
      else
        r_pend <= r_pend | w_req;
      r_on <= w_in_x & w_in_y;
    end
  end

  assign o_on   = r_on;
  assign o_R    = r_on ? C_FLD.r : '0;
  assign o_G    = r_on ? C_FLD.g : '0;
  assign o_B    = r_on ? C_FLD.b : '0;
  assign o_xpos = r_xpos;
  assign o_ypos = r_ypos;

endmodule

// File: tb/tb_sprite_mover.sv
// tb/tb_sprite_mover.sv - self-checking bench for sprite_mover
module tb_sprite_mover;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] px, py;
  logic       frame;
  logic       mode;
  logic [3:0] btn;   // {down, up, right, left}
  logic [4:0] o_R;
  logic [5:0] o_G;
  logic [4:0] o_B;
  logic       o_on;
  logic [9:0] o_xpos, o_ypos;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [3:0] B_L = 4'b0001;
  localparam logic [3:0] B_R = 4'b0010;
  localparam logic [3:0] B_U = 4'b0100;
  localparam logic [3:0] B_D = 4'b1000;

  always #5 clk = ~clk;

  sprite_mover dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_x    (px),
    .i_y    (py),
    .i_frame(frame),
    .i_mode (mode),
    .left   (btn[0]),
    .right  (btn[1]),
    .up     (btn[2]),
    .down   (btn[3]),
    .o_R    (o_R),
    .o_G    (o_G),
    .o_B    (o_B),
    .o_on   (o_on),
    .o_xpos (o_xpos),
    .o_ypos (o_ypos)
  );

  typedef struct {
    int x;
    int y;
    int on;
    int r;
    int g;
    int b;
  } pix_vec_t;

  pix_vec_t pix_tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic check_pos(input string name, input int ex, input int ey);
    check({name, "_x"}, int'(o_xpos), ex);
    check({name, "_y"}, int'(o_ypos), ey);
  endtask

  // Debounced press then release; leaves one pending move per pressed button.
  task automatic tap(input logic [3:0] mask);
    btn = mask;
    repeat (8) tick();
    btn = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic hold(input logic [3:0] mask, input int nframes);
    btn = mask;
    repeat (8) tick();
    for (int i = 0; i < nframes; i++) begin
      frame_pulse();
      tick();
    end
    btn = 4'b0000;
    repeat (8) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst   = 1'b1;
    px    = '0;
    py    = '0;
    frame = 1'b0;
    mode  = 1'b0;
    btn   = 4'b0000;

    pix_tbl[0] = '{375, 215, 1, 0, 63, 31};
    pix_tbl[1] = '{374, 215, 0, 0, 0, 0};
    pix_tbl[2] = '{424, 264, 1, 0, 63, 31};
    pix_tbl[3] = '{425, 264, 0, 0, 0, 0};
    pix_tbl[4] = '{375, 214, 0, 0, 0, 0};
    pix_tbl[5] = '{424, 265, 0, 0, 0, 0};
    pix_tbl[6] = '{400, 240, 1, 0, 63, 31};
    pix_tbl[7] = '{0, 0, 0, 0, 0, 0};

    // Reset state
    px = 10'd375;
    py = 10'd215;
    tick();
    tick();
    check("rst_on", int'(o_on), 0);
    check("rst_G", int'(o_G), 0);
    check_pos("rst_pos", 375, 215);
    rst = 1'b0;

    // Pixel scan, one cycle of latency
    foreach (pix_tbl[i]) begin
      px = 10'(pix_tbl[i].x);
      py = 10'(pix_tbl[i].y);
      tick();
      check($sformatf("pix%0d_on", i), int'(o_on), pix_tbl[i].on);
      check($sformatf("pix%0d_R", i), int'(o_R), pix_tbl[i].r);
      check($sformatf("pix%0d_G", i), int'(o_G), pix_tbl[i].g);
      check($sformatf("pix%0d_B", i), int'(o_B), pix_tbl[i].b);
    end

    // Manual single step, applied only on the tick
    tap(B_R);
    check_pos("right_before_frame", 375, 215);
    frame_pulse();
    check_pos("right_after_frame", 376, 215);

    tap(B_L | B_R);
    frame_pulse();
    check_pos("left_right_cancel", 376, 215);

    // Auto-repeat: 30 frames held gives 4 moves
    hold(B_U, 30);
    check_pos("repeat_up", 376, 211);

    // Glitch shorter than the debounce window
    btn = B_R;
    tick();
    tick();
    btn = 4'b0000;
    repeat (8) tick();
    frame_pulse();
    check_pos("glitch", 376, 211);

    // Reset with a move pending
    btn = B_R;
    repeat (8) tick();
    rst = 1'b1;
    btn = 4'b0000;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    frame_pulse();
    check_pos("reset_pending", 375, 215);

    // Left clamp: 376 attempted moves from 375
    hold(B_L, 1517);
    check_pos("clamp_left_hold", 0, 215);
    tap(B_L);
    frame_pulse();
    check_pos("clamp_left_tap", 0, 215);

    // Corner bounce at (750,430)
    do_reset();
    hold(B_R | B_D, 869);
    check_pos("to_589_429", 589, 429);
    hold(B_R, 653);
    check_pos("to_749_429", 749, 429);
    mode = 1'b1;
    repeat (4) tick();
    check_pos("mode_no_frame", 749, 429);
    frame_pulse();
    check_pos("corner_hit", 750, 430);
    frame_pulse();
    check_pos("corner_after1", 749, 429);
    frame_pulse();
    check_pos("corner_after2", 748, 428);
    mode = 1'b0;
    frame_pulse();
    check_pos("back_manual", 748, 428);
    tap(B_D);
    frame_pulse();
    tap(B_D);
    frame_pulse();
    check_pos("down_to_430", 748, 430);
    tap(B_D);
    frame_pulse();
    check_pos("clamp_down", 748, 430);

    // Single-axis bounce at the right edge from (749,100)
    do_reset();
    hold(B_R | B_U, 473);
    check_pos("to_490_100", 490, 100);
    hold(B_R, 1049);
    check_pos("to_749_100", 749, 100);
    mode = 1'b1;
    frame_pulse();
    check_pos("edge_hit", 750, 101);
    frame_pulse();
    check_pos("edge_after", 749, 102);
    tap(B_L);
    frame_pulse();
    check_pos("bounce_ignores_btn", 748, 103);
    mode = 1'b0;
    frame_pulse();
    check_pos("no_stale_pending", 748, 103);

    // Compare follows the new position
    px = 10'd748;
    py = 10'd103;
    tick();
    check("moved_pix_in", int'(o_on), 1);
    px = 10'd747;
    tick();
    check("moved_pix_out", int'(o_on), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
